// File: rtl/alu_ctrl_8.sv
// alu_ctrl_8: sequences a 4-entry register file and flag register around an external combinational ALU.
// Optional macro ALU_CTRL_CARRY_CHAIN_EN feeds the stored C flag into chained ADD/SUB.
module alu_ctrl_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs1,
  input  logic [1:0]       cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_use_imm,
  input  logic             cmd_use_carry,
  input  logic             cmd_upd_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_c_in,
  output logic             alu_en,
  output logic             alu_update_flags,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c_out,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       rd;
  logic [WIDTH-1:0] b_sel;
  logic             chain;
  logic             c_sel;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
  assign chain = cmd_use_carry;
`else
  logic unused_use_carry;
  assign unused_use_carry = cmd_use_carry;
  assign chain = 1'b0;
`endif
  always_comb begin
    b_sel = cmd_use_imm ? cmd_imm : regs[cmd_rs2];
    c_sel = (cmd_op == 3'b000) ? (chain & flags[3]) :
            (cmd_op == 3'b001) ? (chain ? flags[3] : 1'b1) : 1'b0;
  end
  // ALU operands are registered at accept; regs/flags cannot change before EXEC ends
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      flags            <= '0;
      rsp_data         <= '0;
      rsp_valid        <= 1'b0;
      cmd_ready        <= 1'b1;
      rd               <= '0;
      alu_a            <= '0;
      alu_b            <= '0;
      alu_op           <= '0;
      alu_c_in         <= 1'b0;
      alu_en           <= 1'b0;
      alu_update_flags <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          state            <= EXEC;
          cmd_ready        <= 1'b0;
          rd               <= cmd_rd;
          alu_a            <= regs[cmd_rs1];
          alu_b            <= b_sel;
          alu_op           <= cmd_op;
          alu_c_in         <= c_sel;
          alu_en           <= 1'b1;
          alu_update_flags <= cmd_upd_flags;
        end
        EXEC: begin
          state            <= RESP;
          regs[rd]         <= alu_y;
          rsp_data         <= alu_y;
          rsp_valid        <= 1'b1;
          if (alu_update_flags) begin
            flags[2:0] <= {alu_z, alu_n, alu_v};
            if (alu_op[2:1] == 2'b00) flags[3] <= alu_c_out;
          end
          alu_a            <= '0;
          alu_b            <= '0;
          alu_op           <= '0;
          alu_c_in         <= 1'b0;
          alu_en           <= 1'b0;
          alu_update_flags <= 1'b0;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_8.sv
// tb_alu_ctrl_8: random and directed commands against a register/flag model, with a behavioural ALU attached.
module tb_alu_ctrl_8;
  localparam int W = 8;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [2:0] cmd_op = 0;
  logic [1:0] cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0;
  logic [W-1:0] cmd_imm = 0;
  logic cmd_use_imm = 0, cmd_use_carry = 0, cmd_upd_flags = 0;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_op;
  logic alu_c_in, alu_en, alu_update_flags, alu_c_out, alu_z, alu_n, alu_v;
  logic rsp_valid, rsp_ready = 0;
  logic [W-1:0] rsp_data;
  logic [3:0] flags;
  logic [W-1:0] reg_m [4];
  logic [3:0] flags_m;
  int n_tests = 0, n_fail = 0;

  alu_ctrl_8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm), .cmd_use_carry(cmd_use_carry), .cmd_upd_flags(cmd_upd_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in), .alu_en(alu_en),
    .alu_update_flags(alu_update_flags), .alu_y(alu_y), .alu_c_out(alu_c_out), .alu_z(alu_z),
    .alu_n(alu_n), .alu_v(alu_v), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .flags(flags)
  );

  always #5 clk = ~clk;

  // returns {c, z, n, v, y}; logic ops drive c_out=1 which the controller must not store
  function automatic logic [W+3:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, b, input logic ci);
    logic [W:0] s;
    logic [W-1:0] y;
    logic c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(ci); y = s[W-1:0]; c = s[W];
                  v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci); y = s[W-1:0]; c = s[W];
                  v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]); end
      3'd2: begin y = a & b; c = 1'b1; end
      3'd3: begin y = a | b; c = 1'b1; end
      3'd4: begin y = a ^ b; c = 1'b1; end
      3'd5: begin y = ~a; c = 1'b1; end
      3'd6: begin y = a << 1; c = a[W-1]; end
      default: begin y = a >> 1; c = a[0]; end
    endcase
    return {c, y == '0, y[W-1], v, y};
  endfunction

  always_comb {alu_c_out, alu_z, alu_n, alu_v, alu_y} = alu_fn(alu_op, alu_a, alu_b, alu_c_in);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 0; rsp_ready = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) reg_m[i] = '0;
    flags_m = '0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_flags", flags, 0);
    chk("rst_rsp_data", rsp_data, 0);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] rd, rs1, rs2, input logic [W-1:0] imm,
                        input logic ui, uc, upd, input int hold, input int rst_at);
    logic [W-1:0] a, b;
    logic ci;
    logic [W+3:0] r;
    a = reg_m[rs1];
    b = ui ? imm : reg_m[rs2];
    ci = (op == 3'd0) ? (CHAIN && uc && flags_m[3]) :
         (op == 3'd1) ? ((CHAIN && uc) ? flags_m[3] : 1'b1) : 1'b0;
    r = alu_fn(op, a, b, ci);
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_use_imm = ui; cmd_use_carry = uc; cmd_upd_flags = upd;
    @(negedge clk);
    cmd_valid = 0; cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
    cmd_rs2 = 2'($urandom); cmd_imm = W'($urandom); cmd_use_imm = 1'($urandom);
    cmd_use_carry = 1'($urandom); cmd_upd_flags = 1'($urandom);
    chk("exec_alu_en", alu_en, 1);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", alu_op, op);
    chk("exec_alu_c_in", alu_c_in, ci);
    chk("exec_alu_upd", alu_update_flags, upd);
    chk("exec_cmd_ready", cmd_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    if (rst_at == 1) begin do_reset(); return; end
    reg_m[rd] = r[W-1:0];
    if (upd) begin
      flags_m[2:0] = r[W+2:W];
      if (op < 3'd2) flags_m[3] = r[W+3];
    end
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, r[W-1:0]);
    chk("resp_flags", flags, flags_m);
    chk("resp_alu_en", alu_en, 0);
    chk("resp_alu_a", alu_a, 0);
    chk("resp_cmd_ready", cmd_ready, 0);
    if (rst_at == 2) begin do_reset(); return; end
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, r[W-1:0]);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_alu_en", alu_en, 0);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_alu_en", alu_en, 0);
  endtask

  initial begin
    do_reset();
    do_cmd(3'd3, 2'd1, 2'd0, 2'd0, 8'h7F, 1, 0, 1, 0, 0);
    chk("or_data", rsp_data, 8'h7F);
    chk("or_flags", flags, 4'b0000);
    do_cmd(3'd0, 2'd2, 2'd1, 2'd0, 8'h01, 1, 0, 1, 0, 0);
    chk("add_data", rsp_data, 8'h80);
    chk("add_flags", flags, 4'b0011);
    do_cmd(3'd1, 2'd3, 2'd1, 2'd1, 8'h00, 0, 0, 1, 5, 0);
    chk("sub_data", rsp_data, 8'h00);
    chk("sub_flags", flags, 4'b1100);
    do_cmd(3'd3, 2'd0, 2'd3, 2'd3, 8'h00, 0, 0, 0, 1, 0);
    chk("fwd_r3", rsp_data, 8'h00);
    do_cmd(3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1, 1, 1, 0, 0);
    chk("carry_add", rsp_data, CHAIN ? 8'h01 : 8'h00);
    do_cmd(3'd0, 2'd2, 2'd2, 2'd2, 8'h00, 0, 0, 1, 0, 0);
    chk("same_idx", rsp_data, 8'h00);
    do_cmd(3'd4, 2'd1, 2'd1, 2'd0, 8'h5A, 1, 0, 1, 0, 1);
    chk("exec_rst_flags", flags, 0);
    for (int i = 0; i < 4; i++) do_cmd(3'd3, 2'(i), 2'(i), 2'(i), 8'h00, 0, 0, 0, 0, 0);
    do_cmd(3'd3, 2'd1, 2'd0, 2'd0, 8'hC3, 1, 0, 1, 2, 2);
    for (int i = 0; i < 60; i++)
      do_cmd(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), W'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_8.md
ALU_CTRL_8 -- requirements
Module: alu_ctrl_8

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width; SHALL be >= 2.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-005 cmd_op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LSL, 111 LSR.
REQ-006 cmd_rd, cmd_rs1, cmd_rs2  in  2 each  destination and source indices into the 4-entry register file.
REQ-007 cmd_imm  in  WIDTH  immediate value; cmd_use_imm  in  1  selects cmd_imm instead of reg[rs2] as B.
REQ-008 cmd_use_carry  in  1  carry-chain request; cmd_upd_flags  in  1  flag-update request.
REQ-009 alu_a, alu_b  out  WIDTH  ALU operands; alu_op  out  3; alu_c_in, alu_en, alu_update_flags  out  1 each.
REQ-010 alu_y  in  WIDTH; alu_c_out, alu_z, alu_n, alu_v  in  1 each  combinational ALU results.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake; rsp_data  out  WIDTH  result.
REQ-012 flags  out  4  stored {C,Z,N,V}, bit 3 = C.

Function
REQ-013 FSM states: IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: on cmd_valid=1, latch all cmd_* fields and go to EXEC; otherwise stay.
REQ-015 EXEC lasts exactly one cycle: alu_en=1, alu_a=reg[rs1], alu_b=cmd_imm or reg[rs2], alu_op=cmd_op, alu_update_flags=cmd_upd_flags.
REQ-016 alu_c_in SHALL be 0 for ADD and 1 for SUB when carry chaining is not applied; 0 for all other operations.
REQ-017 At the end of EXEC: reg[rd] <= alu_y; rsp_data <= alu_y; next state RESP.
REQ-018 At the end of EXEC with cmd_upd_flags=1: Z,N,V <= alu_z,alu_n,alu_v; C <= alu_c_out only for ADD/SUB, otherwise C is unchanged; with cmd_upd_flags=0, flags are unchanged.
REQ-019 Outside EXEC: alu_a, alu_b, alu_op, alu_c_in, alu_en and alu_update_flags SHALL all be 0.
REQ-020 RESP: rsp_valid=1; rsp_data is held stable until rsp_ready=1; the state then returns to IDLE.
REQ-021 Latency: command accepted at edge T; rsp_valid=1 from cycle T+2; minimum command spacing is 3 cycles.
REQ-022 A source index equal to the previous command's rd SHALL read the written-back value (writeback precedes the next EXEC).
REQ-023 rs1==rs2==rd in one command: both operands read the old value, then rd is overwritten.
REQ-024 cmd_valid is ignored outside IDLE; a command is never lost or duplicated.

Reset
REQ-025 rst=1 at an edge, in any state including EXEC or RESP: state <= IDLE; all 4 registers <= 0; flags <= 0; rsp_data <= 0; the in-flight command is discarded.
REQ-026 During and after reset: rsp_valid=0, cmd_ready=1 (from the first post-reset cycle), alu_en=0.

Configuration
REQ-027 Macro ALU_CTRL_CARRY_CHAIN_EN defined: for ADD/SUB with cmd_use_carry=1, alu_c_in = stored C flag; otherwise REQ-016 applies.
REQ-028 Macro undefined: cmd_use_carry is ignored and REQ-016 always applies; the port remains present.

Verification
REQ-029 Reset, then OR r1=r0|imm 0x7F with upd -> rsp_data=0x7F, flags=0000, reg1=0x7F.
REQ-030 ADD r2=r1+imm 0x01 with upd -> rsp_data=0x80, flags C=0, Z=0, N=1, V=1 (flags=0011).
REQ-031 SUB r3=r1-r1 with upd -> rsp_data=0x00, C=1, Z=1, N=0, V=0; a following command reading r3 gets 0x00.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid=1 and rsp_data stable; cmd_ready=0; a command presented meanwhile is accepted only after the handshake.
REQ-033 C=1, then ADD r0+imm 0x00 with use_carry -> 0x01 with macro defined, 0x00 without.
REQ-034 rst pulsed during EXEC -> next cycle cmd_ready=1, rsp_valid=0, flags=0, all registers 0.
